// File: rtl/signed_block_acc.sv
// ---------------------------------------------------------------------------
// signed_block_acc
//   Sums BLOCK signed samples into a signed ACC_W-bit accumulator, then holds
//   the result until the downstream side takes it.
//   Overflow handling is per sample: with SAT=1 the accumulator clamps to the
//   nearest bound, and with SAT=0 it wraps. In both cases the sticky 'sat'
//   flag is set.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   clear      synchronous discard of the partial block (ignored in HOLD)
//   in_valid   sample 'a' is valid
//   in_ready   block can accept a sample (state ACC)
//   a          signed N-bit sample
//   out_valid  result valid and held (state HOLD)
//   out_ready  downstream accepts the held result
//   sum        signed accumulator; running value in ACC, final value in HOLD
//   sat        clamp/wrap happened at least once in this block
//   cnt        samples accepted in the current block
// ---------------------------------------------------------------------------
module signed_block_acc #(
    parameter int N     = 8,
    parameter int ACC_W = 12,
    parameter int BLOCK = 4,
    parameter int SAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [N-1:0]     a,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] sum,
    output logic                    sat,
    output logic [7:0]              cnt
);

    typedef enum logic {ST_ACC, ST_HOLD} state_t;

    localparam logic signed [ACC_W-1:0] MAX_V    = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V    = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]              LAST_CNT = 8'(BLOCK - 1);

    state_t                  state_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    sat_q;
    logic [7:0]              cnt_q;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic signed [ACC_W:0]   ext_sum;
    logic                    ovf;

    // Add at ACC_W+1 bits. The top two bits differ exactly when the true sum
    // falls outside the ACC_W-bit signed range.
    always_comb begin
        ext_sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-N){a[N-1]}}, a};
        ovf     = ext_sum[ACC_W] ^ ext_sum[ACC_W-1];
        acc_d   = ext_sum[ACC_W-1:0];
        if (ovf && (SAT != 0)) begin
            // Clamp toward the sign of the true (wide) result.
            acc_d = ext_sum[ACC_W] ? MIN_V : MAX_V;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    if (clear) begin
                        // clear wins over a same-cycle sample
                        acc_q <= '0;
                        sat_q <= 1'b0;
                        cnt_q <= '0;
                    end else if (in_valid) begin
                        acc_q <= acc_d;
                        sat_q <= sat_q | ovf;
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= ST_HOLD;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Result stays frozen (clear ignored) until it is taken.
                    if (out_ready) begin
                        state_q     <= ST_ACC;
                        acc_q       <= '0;
                        sat_q       <= 1'b0;
                        cnt_q       <= '0;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_ACC;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = acc_q;
    assign sat       = sat_q;
    assign cnt       = cnt_q;

endmodule

// File: tb/tb_signed_block_acc.sv
// ---------------------------------------------------------------------------
// tb_signed_block_acc
//   Three instances share the same inputs:
//     u0: ACC_W=9,  SAT=1
//     u1: ACC_W=9,  SAT=0
//     u2: ACC_W=12, SAT=0
//   A per-sample integer reference model tracks each instance. Directed steps
//   come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_signed_block_acc;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [7:0] a = '0;

    logic in_ready0, in_ready1, in_ready2;
    logic out_valid0, out_valid1, out_valid2;
    logic sat0, sat1, sat2;
    logic [7:0] cnt0, cnt1, cnt2;
    logic signed [8:0]  sum0, sum1;
    logic signed [11:0] sum2;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // reference model state, one entry per instance
    int cw[3]   = '{9, 9, 12};
    int satm[3] = '{1, 0, 0};
    int m_acc[3];
    int m_cnt[3];
    bit m_sat[3];
    bit m_hold[3];

    always #5 clk = ~clk;

    signed_block_acc #(.N(8), .ACC_W(9), .BLOCK(4), .SAT(1)) u0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0), .sat(sat0), .cnt(cnt0));
    signed_block_acc #(.N(8), .ACC_W(9), .BLOCK(4), .SAT(0)) u1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1), .sat(sat1), .cnt(cnt1));
    signed_block_acc #(.N(8), .ACC_W(12), .BLOCK(4), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
        .a(a), .out_valid(out_valid2), .out_ready(out_ready), .sum(sum2), .sat(sat2), .cnt(cnt2));

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0; m_cnt[k] = 0; m_sat[k] = 0; m_hold[k] = 0;
        end
    endtask

    // Behaviour at one rising edge, expressed with plain integer arithmetic.
    task automatic model_edge(input bit v, input int av, input bit clr, input bit ordy);
        int hi, lo, s;
        for (int k = 0; k < 3; k++) begin
            hi = (1 << (cw[k] - 1)) - 1;
            lo = -(1 << (cw[k] - 1));
            if (m_hold[k]) begin
                if (ordy) begin
                    m_hold[k] = 0; m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
                end
            end else if (clr) begin
                m_acc[k] = 0; m_sat[k] = 0; m_cnt[k] = 0;
            end else if (v) begin
                s = m_acc[k] + av;
                if (s > hi) begin
                    m_sat[k] = 1;
                    s = (satm[k] != 0) ? hi : s - (1 << cw[k]);
                end else if (s < lo) begin
                    m_sat[k] = 1;
                    s = (satm[k] != 0) ? lo : s + (1 << cw[k]);
                end
                m_acc[k] = s;
                m_cnt[k]++;
                if (m_cnt[k] == 4) m_hold[k] = 1;
            end
        end
    endtask

    task automatic get_obs(input int k, output int s, output int st, output int c,
                           output int ov, output int ir);
        case (k)
            0: begin s = int'(sum0); st = int'(sat0); c = int'(cnt0); ov = int'(out_valid0); ir = int'(in_ready0); end
            1: begin s = int'(sum1); st = int'(sat1); c = int'(cnt1); ov = int'(out_valid1); ir = int'(in_ready1); end
            default: begin s = int'(sum2); st = int'(sat2); c = int'(cnt2); ov = int'(out_valid2); ir = int'(in_ready2); end
        endcase
    endtask

    task automatic check_all(input string ph);
        int s, st, c, ov, ir;
        for (int k = 0; k < 3; k++) begin
            get_obs(k, s, st, c, ov, ir);
            chk($sformatf("%s_u%0d_sum", ph, k), s, m_acc[k]);
            chk($sformatf("%s_u%0d_sat", ph, k), st, int'(m_sat[k]));
            chk($sformatf("%s_u%0d_cnt", ph, k), c, m_cnt[k]);
            chk($sformatf("%s_u%0d_ovalid", ph, k), ov, int'(m_hold[k]));
            chk($sformatf("%s_u%0d_iready", ph, k), ir, int'(!m_hold[k]));
        end
    endtask

    // Called at a falling edge; drives inputs, takes one rising edge and
    // checks at the next falling edge.
    task automatic step(input string ph, input bit v, input int av, input bit clr, input bit ordy);
        in_valid = v; a = 8'(av); clear = clr; out_ready = ordy;
        @(posedge clk);
        model_edge(v, av, clr, ordy);
        @(negedge clk);
        check_all(ph);
    endtask

    task automatic blk4(input string ph, input int x0, input int x1, input int x2, input int x3);
        step(ph, 1, x0, 0, 1);
        step(ph, 1, x1, 0, 1);
        step(ph, 1, x2, 0, 1);
        step(ph, 1, x3, 0, 1);
    endtask

    // Reset pulse strictly between clock edges; outputs must react at once.
    task automatic rst_pulse(input string ph);
        int s, st, c, ov, ir;
        in_valid = 0; clear = 0;
        #2 rst = 1;
        #1;
        for (int k = 0; k < 3; k++) begin
            get_obs(k, s, st, c, ov, ir);
            chk($sformatf("%s_rst_u%0d_sum", ph, k), s, 0);
            chk($sformatf("%s_rst_u%0d_sat", ph, k), st, 0);
            chk($sformatf("%s_rst_u%0d_cnt", ph, k), c, 0);
            chk($sformatf("%s_rst_u%0d_ovalid", ph, k), ov, 0);
            chk($sformatf("%s_rst_u%0d_iready", ph, k), ir, 1);
        end
        model_reset();
        #1 rst = 0;
    endtask

    initial begin
        logic signed [7:0] r;
        int av;
        model_reset();

        // power-on reset
        #1 rst = 1;
        #2 check_all("por");
        @(negedge clk);
        rst = 0;

        // 1,1,1,1 -> 4
        blk4("r31", 1, 1, 1, 1);
        chk("r31_ovalid", int'(out_valid0), 1);
        chk("r31_sum", int'(sum0), 4);
        chk("r31_sat", int'(sat0), 0);
        step("r31d", 0, 0, 0, 1);
        chk("r31_cnt_after", int'(cnt0), 0);
        chk("r31_iready_after", int'(in_ready0), 1);

        // positive overflow: clamp, wrap, and no overflow at 12 bits
        blk4("r32a", 127, 127, 127, 127);
        chk("r32a_sum_sat1", int'(sum0), 255);
        chk("r32a_flag_sat1", int'(sat0), 1);
        chk("r33_sum_wrap", int'(sum1), -4);
        chk("r33_flag_wrap", int'(sat1), 1);
        chk("r33_sum_w12", int'(sum2), 508);
        chk("r33_flag_w12", int'(sat2), 0);
        step("r32ad", 0, 0, 0, 1);

        // negative clamp
        blk4("r32b", -128, -128, -128, -128);
        chk("r32b_sum", int'(sum0), -256);
        chk("r32b_flag", int'(sat0), 1);
        step("r32bd", 0, 0, 0, 1);

        // clamped value moves back inside range
        blk4("r32c", 127, 127, 127, -128);
        chk("r32c_sum", int'(sum0), 127);
        chk("r32c_flag", int'(sat0), 1);
        step("r32cd", 0, 0, 0, 1);

        // clear drops the partial block and the same-cycle sample
        step("r34", 1, 5, 0, 1);
        step("r34", 1, -3, 0, 1);
        step("r34", 0, 0, 0, 1);
        step("r34", 1, 9, 1, 1);
        chk("r34_cnt_clr", int'(cnt0), 0);
        blk4("r34", 2, 2, 2, 2);
        chk("r34_sum", int'(sum0), 8);
        step("r34d", 0, 0, 0, 1);

        // held result survives in_valid and clear while out_ready=0
        blk4("r35", 3, 3, 3, 3);
        for (int i = 0; i < 10; i++) begin
            step("r35h", 1, 7, 1, 0);
            chk("r35_sum_held", int'(sum0), 12);
            chk("r35_iready", int'(in_ready0), 0);
        end
        step("r35d", 1, 7, 1, 1);
        chk("r35_iready_back", int'(in_ready0), 1);
        chk("r35_cnt_back", int'(cnt0), 0);

        // reset mid-block and during HOLD
        step("r36", 1, 1, 0, 1);
        step("r36", 1, 2, 0, 1);
        rst_pulse("r36a");
        blk4("r36", 5, 6, 7, 8);
        rst_pulse("r36b");
        blk4("r36", 1, 2, 3, 4);
        chk("r36_sum", int'(sum0), 10);
        step("r36d", 0, 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) rst_pulse("rnd");
            r = 8'($urandom);
            av = int'(r);
            if ($urandom_range(0, 3) == 0) av = ($urandom_range(0, 1) != 0) ? 127 : -128;
            step("rnd", ($urandom_range(0, 9) < 7), av, ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 1) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
